// File: rtl/onchip_arb_pkg.sv
// Shared encodings and default widths for the on-chip pattern memory arbiter.
// Used by onchip_mem_arbiter and its testbench.
package onchip_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned DATA_W_DEF = 256;

  // Owner tag carried alongside each read through the return pipeline.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_A_OWN = 2'd1,
    ST_B_OWN = 2'd2
  } state_e;

  function automatic owner_e read_owner(input logic a_gnt, input logic b_gnt,
                                        input logic b_we);
    owner_e own;
    own = OWN_NONE;
    if (a_gnt)               own = OWN_A;
    else if (b_gnt && !b_we) own = OWN_B;
    return own;
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (inc_i && ~&cnt_q)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-port arbiter in front of the single-port pattern memory: A (fetch, read-only)
// has priority, B (loader) is forced in after STARVE_LIMIT A grants. ONCHIP_ARB_STATS_EN adds grant/stall counters.
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_req,
  input  logic [ADDR_W-1:0]   a_addr,
  output logic                a_gnt,
  output logic                a_rvalid,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic                b_gnt,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                mem_chip_select,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  output logic [DATA_W-1:0]   mem_write_data,
  input  logic [DATA_W-1:0]   mem_read_data,
  output state_e              dbg_state
`ifdef ONCHIP_ARB_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [15:0]         a_grant_cnt,
  output logic [15:0]         b_grant_cnt,
  output logic [15:0]         b_stall_cnt
`endif
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [7:0] STARVE_MAX = STARVE_LIMIT[7:0];

  // Handshake: a requester raises req with stable fields and holds them until it
  // sees gnt high in the same cycle; that cycle is the acceptance, one access each.
  logic a_gnt_w, b_gnt_w;

  state_e              state_q, state_d;
  logic [7:0]          starve_q, starve_d;
  logic                cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  owner_e              tag1_q, tag1_d, tag2_q;

  always_comb begin
    b_gnt_w = rst_n & b_req & (~a_req | (starve_q == STARVE_MAX));
    a_gnt_w = rst_n & a_req & ~b_gnt_w;
  end

  always_comb begin
    state_d = ST_IDLE;
    if (a_gnt_w)      state_d = ST_A_OWN;
    else if (b_gnt_w) state_d = ST_B_OWN;

    starve_d = starve_q;
    if (!b_req || b_gnt_w)                  starve_d = 8'd0;
    else if (a_gnt_w && starve_q != STARVE_MAX) starve_d = starve_q + 8'd1;

    // Address and data buses hold their last value when nothing is granted.
    cs_d   = 1'b0;
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    addr_d = addr_q;
    be_d   = be_q;
    wd_d   = wd_q;
    if (a_gnt_w) begin
      cs_d   = 1'b1;
      rd_d   = 1'b1;
      addr_d = a_addr;
    end else if (b_gnt_w) begin
      cs_d   = 1'b1;
      addr_d = b_addr;
      if (b_we) begin
        wr_d = 1'b1;
        be_d = b_be;
        wd_d = b_wdata;
      end else begin
        rd_d = 1'b1;
      end
    end

    tag1_d = read_owner(a_gnt_w, b_gnt_w, b_we);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= 8'd0;
      cs_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wd_q     <= '0;
      tag1_q   <= OWN_NONE;
      tag2_q   <= OWN_NONE;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      cs_q     <= cs_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wd_q     <= wd_d;
      tag1_q   <= tag1_d;
      tag2_q   <= tag1_q;
    end
  end

  assign a_gnt           = a_gnt_w;
  assign b_gnt           = b_gnt_w;
  assign mem_chip_select = cs_q;
  assign mem_read        = rd_q;
  assign mem_write       = wr_q;
  assign mem_addr        = addr_q;
  assign mem_byte_enable = be_q;
  assign mem_write_data  = wd_q;
  assign dbg_state       = state_q;

  // The tag two stages back marks which requester owns this cycle's read data.
  assign a_rvalid = (tag2_q == OWN_A);
  assign b_rvalid = (tag2_q == OWN_B);
  assign a_rdata  = mem_read_data;
  assign b_rdata  = mem_read_data;

`ifdef ONCHIP_ARB_STATS_EN
  arb_sat_counter #(.W(16)) u_a_grant_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (stats_clr),
    .inc_i (a_gnt_w),
    .cnt_o (a_grant_cnt)
  );

  arb_sat_counter #(.W(16)) u_b_grant_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (stats_clr),
    .inc_i (b_gnt_w),
    .cnt_o (b_grant_cnt)
  );

  arb_sat_counter #(.W(16)) u_b_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (stats_clr),
    .inc_i (b_req & ~b_gnt_w),
    .cnt_o (b_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a 64-word behavioural memory behind it.
// Define ONCHIP_ARB_STATS_EN to also exercise the counters.
module tb_onchip_mem_arbiter;
  import onchip_arb_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [10:0]   a_addr = '0, b_addr = '0;
  logic [31:0]   b_be = '0;
  logic [255:0]  b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [255:0]  a_rdata, b_rdata;
  logic          mem_chip_select, mem_read, mem_write;
  logic [10:0]   mem_addr;
  logic [31:0]   mem_byte_enable;
  logic [255:0]  mem_write_data;
  logic [255:0]  mem_read_data = '0;
  state_e        dbg_state;

  logic          a_gnt1, b_gnt1, a_rvalid1, b_rvalid1;
  logic [255:0]  a_rdata1, b_rdata1, wd1;
  logic          cs1, rd1, wr1;
  logic [10:0]   addr1;
  logic [31:0]   be1;
  state_e        dbg1;
`ifdef ONCHIP_ARB_STATS_EN
  logic          stats_clr = 1'b0;
  logic [15:0]   a_grant_cnt, b_grant_cnt, b_stall_cnt;
  logic [15:0]   a_grant_cnt1, b_grant_cnt1, b_stall_cnt1;
`endif

  logic [255:0]  mem_arr [64];
  logic [255:0]  exp_mem [64];

  int            n_vec = 0;
  int            n_err = 0;

  // Expected bus state one cycle after grant (s1) and two cycles after (s2).
  logic          s1_cs = 0, s1_rd = 0, s1_wr = 0;
  logic [10:0]   s1_addr = '0;
  logic [31:0]   s1_be = '0;
  logic [255:0]  s1_wd = '0, s1_data = '0, s2_data = '0;
  int            s1_own = 0, s2_own = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.STARVE_LIMIT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_chip_select(mem_chip_select), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_byte_enable(mem_byte_enable), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .dbg_state(dbg_state)
`ifdef ONCHIP_ARB_STATS_EN
    , .stats_clr(stats_clr), .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt),
    .b_stall_cnt(b_stall_cnt)
`endif
  );

  onchip_mem_arbiter #(.STARVE_LIMIT(1)) dut_lim1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
    .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
    .mem_chip_select(cs1), .mem_read(rd1), .mem_write(wr1),
    .mem_addr(addr1), .mem_byte_enable(be1), .mem_write_data(wd1),
    .mem_read_data(256'd0), .dbg_state(dbg1)
`ifdef ONCHIP_ARB_STATS_EN
    , .stats_clr(stats_clr), .a_grant_cnt(a_grant_cnt1), .b_grant_cnt(b_grant_cnt1),
    .b_stall_cnt(b_stall_cnt1)
`endif
  );

  // Memory model: latency 1 from the strobe cycle, byte-enabled writes.
  always @(posedge clk) begin
    if (mem_chip_select && mem_read) mem_read_data <= mem_arr[mem_addr[5:0]];
    if (mem_chip_select && mem_write)
      for (int b = 0; b < 32; b++)
        if (mem_byte_enable[b]) mem_arr[mem_addr[5:0]][b*8 +: 8] <= mem_write_data[b*8 +: 8];
  end

  function automatic logic [255:0] pat(input int a);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(a);
    return {8{w}};
  endfunction

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] nw,
                                         input logic [31:0] be);
    logic [255:0] r;
    r = old;
    for (int b = 0; b < 32; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive requests, check grants and the expected bus/return
  // pipeline, then advance to just after the next rising edge.
  task automatic cycle(input logic ar, input logic [10:0] aa, input logic br, input logic bw,
                       input logic [10:0] ba, input logic [31:0] bbe, input logic [255:0] bwd,
                       input logic eag, input logic ebg);
    a_req = ar; a_addr = aa; b_req = br; b_we = bw; b_addr = ba; b_be = bbe; b_wdata = bwd;
    #1;
    check("a_gnt", a_gnt, eag);
    check("b_gnt", b_gnt, ebg);
    check("mem_chip_select", mem_chip_select, s1_cs);
    check("mem_read", mem_read, s1_rd);
    check("mem_write", mem_write, s1_wr);
    if (s1_cs) check("mem_addr", mem_addr, s1_addr);
    if (s1_wr) begin
      check("mem_byte_enable", mem_byte_enable, s1_be);
      check("mem_write_data", mem_write_data, s1_wd);
    end
    check("a_rvalid", a_rvalid, s2_own == 1);
    check("b_rvalid", b_rvalid, s2_own == 2);
    if (s2_own == 1) check("a_rdata", a_rdata, s2_data);
    if (s2_own == 2) check("b_rdata", b_rdata, s2_data);
    s2_own  = s1_own;
    s2_data = s1_data;
    s1_cs   = eag | ebg;
    s1_rd   = eag | (ebg & ~bw);
    s1_wr   = ebg & bw & ~eag;
    s1_addr = eag ? aa : ba;
    if (s1_wr) begin
      s1_be = bbe;
      s1_wd = bwd;
    end
    s1_own  = eag ? 1 : ((ebg && !bw) ? 2 : 0);
    s1_data = exp_mem[s1_addr[5:0]];
    if (s1_wr) exp_mem[ba[5:0]] = merge(exp_mem[ba[5:0]], bwd, bbe);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 11'd0, 0, 0, 11'd0, 32'd0, 256'd0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = pat(i);
      exp_mem[i] = pat(i);
    end

    // Reset with both requests high: grants must stay low.
    a_req = 1; b_req = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst a_gnt", a_gnt, 0);
    check("rst b_gnt", b_gnt, 0);
    check("rst strobes", {mem_chip_select, mem_read, mem_write}, 3'b000);
    check("rst mem_addr", mem_addr, 0);
    check("rst byte_enable", mem_byte_enable, 0);
    check("rst write_data", mem_write_data, 0);
    check("rst rvalid", {a_rvalid, b_rvalid}, 2'b00);
    check("rst state", dbg_state, ST_IDLE);
`ifdef ONCHIP_ARB_STATS_EN
    check("rst counters", {a_grant_cnt, b_grant_cnt, b_stall_cnt}, 48'd0);
`endif
    a_req = 0; b_req = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;

    // A-only back-to-back reads 0..3.
    for (int i = 0; i < 4; i++) cycle(1, 11'(i), 0, 0, 11'd0, 32'd0, 256'd0, 1, 0);
    idle(3);

    // B full write then read of 0x10, partial write then read of 0x11.
    cycle(0, 11'd0, 1, 1, 11'h10, 32'hFFFF_FFFF, {32{8'hA5}}, 0, 1);
    cycle(0, 11'd0, 1, 0, 11'h10, 32'd0, 256'd0, 0, 1);
    cycle(0, 11'd0, 1, 1, 11'h11, 32'h0000_0001, {32{8'hFF}}, 0, 1);
    cycle(0, 11'd0, 1, 0, 11'h11, 32'd0, 256'd0, 0, 1);
    idle(3);
    check("b_write 0x10 landed", mem_arr[16], {32{8'hA5}});
    check("b_write 0x11 partial", mem_arr[17], {{7{32'hC0DE_0011}}, 32'hC0DE_00FF});

    // Both saturated: limit 16 gives 16 A then 1 B; the limit-1 instance alternates.
    for (int i = 0; i < 34; i++) begin
      a_req = 1; b_req = 1; b_we = 0;
      #1;
      check("lim1 a_gnt", a_gnt1, (i % 2) == 0);
      check("lim1 b_gnt", b_gnt1, (i % 2) == 1);
      cycle(1, 11'(i % 4), 1, 0, 11'h10, 32'd0, 256'd0, (i != 16 && i != 33), (i == 16 || i == 33));
    end
    check("state after B", dbg_state, ST_B_OWN);
    idle(3);
    check("state idle", dbg_state, ST_IDLE);

    // Simultaneous request after idle: A first, B when A drops.
    for (int i = 0; i < 3; i++) cycle(1, 11'(i + 4), 1, 0, 11'h10, 32'd0, 256'd0, 1, 0);
    cycle(0, 11'd0, 1, 0, 11'h10, 32'd0, 256'd0, 0, 1);
    idle(3);

    // Reset one cycle after an A read grant: strobes drop at once, no rvalid later.
    cycle(1, 11'd5, 0, 0, 11'd0, 32'd0, 256'd0, 1, 0);
    check("pre-reset mem_read", mem_read, 1);
    rst_n = 0;
    #1;
    check("async rst strobes", {mem_chip_select, mem_read, mem_write}, 3'b000);
    check("async rst a_gnt", a_gnt, 0);
    check("async rst state", dbg_state, ST_IDLE);
    a_req = 0;
    s1_cs = 0; s1_rd = 0; s1_wr = 0; s1_own = 0; s2_own = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    idle(4);

`ifdef ONCHIP_ARB_STATS_EN
    stats_clr = 1;
    idle(1);
    stats_clr = 0;
    for (int i = 0; i < 20; i++)
      cycle(1, 11'(i % 4), 1, 0, 11'h10, 32'd0, 256'd0, i != 16, i == 16);
    check("a_grant_cnt", a_grant_cnt, 16'd19);
    check("b_grant_cnt", b_grant_cnt, 16'd1);
    check("b_stall_cnt", b_stall_cnt, 16'd19);
    stats_clr = 1;
    idle(1);
    stats_clr = 0;
    check("clr counters", {a_grant_cnt, b_grant_cnt, b_stall_cnt}, 48'd0);
    idle(3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
